// File: rtl/axi_pkg.sv
// Shared AXI4 constants and FSM state types for the burst RAM model.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'b00,
        WR_BURST = 2'b01,
        WR_RESP  = 2'b10
    } wr_state_e;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address: FIXED holds, every other burst type increments by 1<<size.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            size_i,
    input  logic [1:0]            burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] step_s;

    // Step computation; the sum wraps naturally at the address width.
    always_comb begin
        step_s = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_i;
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else begin
            next_addr_o = addr_i + step_s;
        end
    end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 slave RAM with independent write (AW/W/B) and read (AR/R) burst engines.
// Optional: define AXI_RAM_ZERO_INIT_EN to start simulation with an all-zero array.
module axi_burst_ram
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
    localparam int WORD_AW   = ADDR_WIDTH - ADDR_LSB;
    localparam int MEM_DEPTH = 1 << WORD_AW;

    logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];

`ifdef AXI_RAM_ZERO_INIT_EN
    // Simulation-time clear so unwritten locations read back as zero.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] = '0;
        end
    end
`else
`endif

    // ---------------- write engine ----------------
    wr_state_e             wr_state_q, wr_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   wr_id_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_next_addr_s;
    logic [7:0]            wr_len_q;
    logic [7:0]            wr_cnt_q;
    logic [2:0]            wr_size_q;
    logic [1:0]            wr_burst_q;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic [WORD_AW-1:0]    wr_idx_s;

    assign aw_hs_s  = s_axi_awvalid && awready_q;
    assign w_hs_s   = s_axi_wvalid && wready_q;
    assign wr_idx_s = wr_addr_q[ADDR_WIDTH-1:ADDR_LSB];

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr_gen (
        .addr_i      (wr_addr_q),
        .size_i      (wr_size_q),
        .burst_i     (wr_burst_q),
        .next_addr_o (wr_next_addr_s)
    );

    // Write FSM next state; handshake flags are decoded from the next state so they register cleanly.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs_s) wr_state_d = WR_BURST;
                else         wr_state_d = WR_IDLE;
            end
            WR_BURST: begin
                if (w_hs_s && (wr_cnt_q == wr_len_q)) wr_state_d = WR_RESP;
                else                                  wr_state_d = WR_BURST;
            end
            WR_RESP: begin
                if (bvalid_q && s_axi_bready) wr_state_d = WR_IDLE;
                else                          wr_state_d = WR_RESP;
            end
            default: wr_state_d = WR_IDLE;
        endcase
        awready_d = (wr_state_d == WR_IDLE);
        wready_d  = (wr_state_d == WR_BURST);
        bvalid_d  = (wr_state_d == WR_RESP);
    end

    // Write FSM state, handshake flags and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= 8'd0;
            wr_cnt_q   <= 8'd0;
            wr_size_q  <= 3'd0;
            wr_burst_q <= 2'd0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            if (aw_hs_s) begin
                wr_id_q    <= s_axi_awid;
                wr_addr_q  <= s_axi_awaddr;
                wr_len_q   <= s_axi_awlen;
                wr_cnt_q   <= 8'd0;
                wr_size_q  <= s_axi_awsize;
                wr_burst_q <= s_axi_awburst;
            end else if (w_hs_s) begin
                wr_addr_q <= wr_next_addr_s;
                wr_cnt_q  <= wr_cnt_q + 8'd1;
            end else begin
                wr_cnt_q <= wr_cnt_q;
            end
        end
    end

    // Byte-lane array write; deliberately unreset so contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_hs_s && s_axi_wstrb[i]) begin
                mem_q[wr_idx_s][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = wr_id_q;
    assign s_axi_bresp   = RESP_OKAY;

    // ---------------- read engine ----------------
    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic [ID_WIDTH-1:0]   rd_id_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [7:0]            rd_len_q;
    logic [7:0]            rd_cnt_q;
    logic [2:0]            rd_size_q;
    logic [1:0]            rd_burst_q;
    logic [ADDR_WIDTH-1:0] fetch_addr_s;
    logic [2:0]            fetch_size_s;
    logic [1:0]            fetch_burst_s;
    logic [ADDR_WIDTH-1:0] rd_next_addr_s;
    logic [WORD_AW-1:0]    fetch_idx_s;
    logic                  ar_hs_s;
    logic                  r0_valid_q;
    logic [DATA_WIDTH-1:0] r0_data_q;
    logic                  r0_last_q;
    logic                  r0_ready_s;
    logic                  r0_hs_s;

    assign ar_hs_s     = s_axi_arvalid && arready_q;
    assign r0_hs_s     = r0_valid_q && r0_ready_s;
    assign fetch_idx_s = fetch_addr_s[ADDR_WIDTH-1:ADDR_LSB];

    // In IDLE beat 0 is fetched straight from the AR channel; afterwards from the tracked address.
    always_comb begin
        if (rd_state_q == RD_IDLE) begin
            fetch_addr_s  = s_axi_araddr;
            fetch_size_s  = s_axi_arsize;
            fetch_burst_s = s_axi_arburst;
        end else begin
            fetch_addr_s  = rd_addr_q;
            fetch_size_s  = rd_size_q;
            fetch_burst_s = rd_burst_q;
        end
    end

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr_gen (
        .addr_i      (fetch_addr_s),
        .size_i      (fetch_size_s),
        .burst_i     (fetch_burst_s),
        .next_addr_o (rd_next_addr_s)
    );

    // Read FSM next state and arready decode.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs_s) rd_state_d = RD_BURST;
                else         rd_state_d = RD_IDLE;
            end
            RD_BURST: begin
                if (r0_hs_s && r0_last_q) rd_state_d = RD_IDLE;
                else                      rd_state_d = RD_BURST;
            end
            default: rd_state_d = RD_IDLE;
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    // Read FSM state and the first output stage; the array read sees pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= 8'd0;
            rd_cnt_q   <= 8'd0;
            rd_size_q  <= 3'd0;
            rd_burst_q <= 2'd0;
            r0_valid_q <= 1'b0;
            r0_data_q  <= '0;
            r0_last_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            if (ar_hs_s) begin
                rd_id_q    <= s_axi_arid;
                rd_len_q   <= s_axi_arlen;
                rd_size_q  <= s_axi_arsize;
                rd_burst_q <= s_axi_arburst;
                rd_addr_q  <= rd_next_addr_s;
                rd_cnt_q   <= 8'd0;
                r0_valid_q <= 1'b1;
                r0_data_q  <= mem_q[fetch_idx_s];
                r0_last_q  <= (s_axi_arlen == 8'd0);
            end else if (r0_hs_s) begin
                if (r0_last_q) begin
                    r0_valid_q <= 1'b0;
                    r0_last_q  <= 1'b0;
                end else begin
                    r0_data_q <= mem_q[fetch_idx_s];
                    rd_addr_q <= rd_next_addr_s;
                    rd_cnt_q  <= rd_cnt_q + 8'd1;
                    r0_last_q <= ((rd_cnt_q + 8'd1) == rd_len_q);
                end
            end else begin
                r0_valid_q <= r0_valid_q;
            end
        end
    end

    generate
        if (PIPELINE_OUTPUT != 0) begin : g_rpipe
            logic                  p_valid_q;
            logic [DATA_WIDTH-1:0] p_data_q;
            logic                  p_last_q;
            logic [ID_WIDTH-1:0]   p_id_q;

            // Stage refills whenever it is empty or being drained, keeping one beat per cycle.
            assign r0_ready_s = !p_valid_q || s_axi_rready;

            // Extra R output register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_valid_q <= 1'b0;
                    p_data_q  <= '0;
                    p_last_q  <= 1'b0;
                    p_id_q    <= '0;
                end else if (r0_ready_s) begin
                    p_valid_q <= r0_valid_q;
                    p_data_q  <= r0_data_q;
                    p_last_q  <= r0_valid_q && r0_last_q;
                    p_id_q    <= rd_id_q;
                end else begin
                    p_valid_q <= p_valid_q;
                end
            end

            assign s_axi_rvalid = p_valid_q;
            assign s_axi_rdata  = p_data_q;
            assign s_axi_rlast  = p_last_q;
            assign s_axi_rid    = p_id_q;
        end else begin : g_rdirect
            assign r0_ready_s   = s_axi_rready;
            assign s_axi_rvalid = r0_valid_q;
            assign s_axi_rdata  = r0_data_q;
            assign s_axi_rlast  = r0_last_q;
            assign s_axi_rid    = rd_id_q;
        end
    endgenerate

    assign s_axi_arready = arready_q;
    assign s_axi_rresp   = RESP_OKAY;

    logic unused_s;
    assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot};

endmodule

// File: tb/tb_axi_burst_ram.sv
// Scoreboard bench: 8-bit instance for burst/stall/reset scenarios, 32-bit instance for strobes.
module tb_axi_burst_ram;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] id;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp32_q[$];
    logic [7:0]  model_mem [0:65535];
    logic [31:0] model32;

    // 8-bit instance signals
    logic [7:0]  awid, arid, bid, rid;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [7:0]  wdata, rdata;
    logic [0:0]  wstrb;

    // 32-bit instance signals
    logic [7:0]  x_awid, x_arid, x_bid, x_rid;
    logic [15:0] x_awaddr, x_araddr;
    logic [7:0]  x_awlen, x_arlen;
    logic [2:0]  x_awsize, x_arsize;
    logic [1:0]  x_awburst, x_arburst, x_bresp, x_rresp;
    logic        x_awvalid, x_awready, x_wvalid, x_wready, x_wlast, x_bvalid, x_bready;
    logic        x_arvalid, x_arready, x_rvalid, x_rready, x_rlast;
    logic [31:0] x_wdata, x_rdata;
    logic [3:0]  x_wstrb;

    axi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STRB_WIDTH(1), .ID_WIDTH(8), .PIPELINE_OUTPUT(0)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    axi_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8), .PIPELINE_OUTPUT(0)) dut32 (
        .clk(clk), .rst(rst),
        .s_axi_awid(x_awid), .s_axi_awaddr(x_awaddr), .s_axi_awlen(x_awlen), .s_axi_awsize(x_awsize),
        .s_axi_awburst(x_awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awvalid(x_awvalid), .s_axi_awready(x_awready),
        .s_axi_wdata(x_wdata), .s_axi_wstrb(x_wstrb), .s_axi_wlast(x_wlast),
        .s_axi_wvalid(x_wvalid), .s_axi_wready(x_wready),
        .s_axi_bid(x_bid), .s_axi_bresp(x_bresp), .s_axi_bvalid(x_bvalid), .s_axi_bready(x_bready),
        .s_axi_arid(x_arid), .s_axi_araddr(x_araddr), .s_axi_arlen(x_arlen), .s_axi_arsize(x_arsize),
        .s_axi_arburst(x_arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arvalid(x_arvalid), .s_axi_arready(x_arready),
        .s_axi_rid(x_rid), .s_axi_rdata(x_rdata), .s_axi_rresp(x_rresp), .s_axi_rlast(x_rlast),
        .s_axi_rvalid(x_rvalid), .s_axi_rready(x_rready)
    );

    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [7:0] id, input logic [31:0] beats);
        int budget;
        logic [15:0] a;
        @(negedge clk);
        budget = 0;
        while (awready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (awready !== 1'b1) begin
            bad++;
            $display("FAIL aw_wait awready=%b want=1", awready);
        end
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'd0; awburst = burst;
        @(negedge clk);
        awvalid = 1'b0;
        total++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            bad++;
            $display("FAIL aw_accept awready=%b wready=%b want 0/1", awready, wready);
        end
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = beats[8*i +: 8]; wstrb = 1'b1; wlast = (i == int'(len));
            model_mem[a] = beats[8*i +: 8];
            if (burst != 2'b00) a = a + 16'd1;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        total++;
        if (bvalid !== 1'b1 || bid !== id || bresp !== 2'b00 || wready !== 1'b0) begin
            bad++;
            $display("FAIL b_resp bvalid=%b bid=%h bresp=%b wready=%b want 1/%h/00/0", bvalid, bid, bresp, wready, id);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            bad++;
            $display("FAIL b_done bvalid=%b awready=%b want 0/1", bvalid, awready);
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] id, input int stall);
        beat_t e;
        int budget;
        logic [15:0] a;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = model_mem[a];
            e.last = (i == int'(len));
            e.id   = id;
            exp_q.push_back(e);
            if (burst != 2'b00) a = a + 16'd1;
        end
        @(negedge clk);
        budget = 0;
        while (arready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = 3'd0; arburst = burst;
        rready = (stall == 0);
        @(negedge clk);
        arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || arready !== 1'b0) begin
            bad++;
            $display("FAIL r_first rvalid=%b arready=%b want 1/0", rvalid, arready);
        end
        for (int c = 0; c < stall; c++) begin
            total++;
            if (rvalid !== 1'b1 || rdata !== exp_q[0].data || rlast !== exp_q[0].last) begin
                bad++;
                $display("FAIL r_stall_hold rvalid=%b rdata=%h rlast=%b want 1/%h/%b", rvalid, rdata, rlast, exp_q[0].data, exp_q[0].last);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            total++;
            if (rvalid !== 1'b1) begin
                bad++;
                $display("FAIL r_bubble rvalid=%b want 1", rvalid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (rdata !== e.data || rlast !== e.last || rid !== e.id || rresp !== 2'b00) begin
                    bad++;
                    $display("FAIL r_beat rdata=%h rlast=%b rid=%h rresp=%b want %h/%b/%h/00", rdata, rlast, rid, rresp, e.data, e.last, e.id);
                end
            end
            @(negedge clk);
            budget++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL r_timeout remaining=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        rready = 1'b0;
        total++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            bad++;
            $display("FAIL r_done rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || arready !== 1'b0 ||
            rvalid !== 1'b0 || rlast !== 1'b0 || bid !== 8'd0 || rid !== 8'd0 || rdata !== 8'd0 ||
            bresp !== 2'b00 || rresp !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs aw=%b w=%b b=%b ar=%b r=%b rl=%b bid=%h rid=%h rd=%h want all 0",
                     awready, wready, bvalid, arready, rvalid, rlast, bid, rid, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (awready !== 1'b1 || arready !== 1'b1 || x_awready !== 1'b1 || x_arready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release awready=%b arready=%b want 1/1", awready, arready);
        end
    endtask

    task automatic test_incr_write_read();
        do_write(16'h0EEF, 8'd3, 2'b01, 8'd5, 32'hD4C3B2A1);
        do_read(16'h0EF2, 8'd0, 2'b01, 8'd5, 0);
    endtask

    task automatic test_read_burst();
        do_read(16'h0EEF, 8'd3, 2'b01, 8'd7, 0);
    endtask

    task automatic test_read_stall();
        do_read(16'h0EEF, 8'd3, 2'b01, 8'd2, 10);
    endtask

    task automatic test_fixed_burst();
        do_write(16'h0011, 8'd0, 2'b01, 8'd1, 32'h00000055);
        do_write(16'h0010, 8'd2, 2'b00, 8'd9, 32'h00030201);
        do_read(16'h0010, 8'd0, 2'b01, 8'd4, 0);
        do_read(16'h0011, 8'd0, 2'b01, 8'd4, 0);
        do_read(16'h0010, 8'd2, 2'b00, 8'd6, 0);
    endtask

    task automatic w32_write(input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        x_awvalid = 1'b1; x_awid = 8'h3C; x_awaddr = 16'h0000; x_awlen = 8'd0; x_awsize = 3'd2; x_awburst = 2'b01;
        @(negedge clk);
        x_awvalid = 1'b0;
        x_wvalid = 1'b1; x_wdata = data; x_wstrb = strb; x_wlast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) model32[8*i +: 8] = data[8*i +: 8];
        end
        @(negedge clk);
        x_wvalid = 1'b0; x_wlast = 1'b0;
        total++;
        if (x_bvalid !== 1'b1 || x_bid !== 8'h3C) begin
            bad++;
            $display("FAIL w32_bresp bvalid=%b bid=%h want 1/3c", x_bvalid, x_bid);
        end
        x_bready = 1'b1;
        @(negedge clk);
        x_bready = 1'b0;
    endtask

    task automatic test_strobe32();
        logic [31:0] e;
        int budget;
        w32_write(32'h00000000, 4'b1111);
        w32_write(32'h11223344, 4'b0101);
        exp32_q.push_back(model32);
        @(negedge clk);
        x_arvalid = 1'b1; x_arid = 8'h21; x_araddr = 16'h0000; x_arlen = 8'd0; x_arsize = 3'd2; x_arburst = 2'b01;
        x_rready = 1'b1;
        @(negedge clk);
        x_arvalid = 1'b0;
        budget = 0;
        while (x_rvalid !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (x_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL r32_timeout rvalid=%b want 1", x_rvalid);
        end else begin
            e = exp32_q.pop_front();
            total++;
            if (x_rdata !== e || x_rlast !== 1'b1 || x_rid !== 8'h21) begin
                bad++;
                $display("FAIL r32_strobe rdata=%h rlast=%b rid=%h want %h/1/21", x_rdata, x_rlast, x_rid, e);
            end
        end
        @(negedge clk);
        x_rready = 1'b0;
        exp32_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        arvalid = 1'b1; arid = 8'h44; araddr = 16'h0EEF; arlen = 8'd3; arsize = 3'd0; arburst = 2'b01;
        rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_start rvalid=%b want 1", rvalid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0 || rdata !== 8'd0 || rid !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_drop rvalid=%b rlast=%b arready=%b rdata=%h rid=%h want 0", rvalid, rlast, arready, rdata, rid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (arready !== 1'b1 || awready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_recover arready=%b awready=%b want 1/1", arready, awready);
        end
        do_read(16'h0EEF, 8'd3, 2'b01, 8'd9, 0);
    endtask

    initial begin
        awid = 8'd0; awaddr = 16'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b01; awvalid = 1'b0;
        wdata = 8'd0; wstrb = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 8'd0; araddr = 16'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        x_awid = 8'd0; x_awaddr = 16'd0; x_awlen = 8'd0; x_awsize = 3'd2; x_awburst = 2'b01; x_awvalid = 1'b0;
        x_wdata = 32'd0; x_wstrb = 4'd0; x_wlast = 1'b0; x_wvalid = 1'b0; x_bready = 1'b0;
        x_arid = 8'd0; x_araddr = 16'd0; x_arlen = 8'd0; x_arsize = 3'd2; x_arburst = 2'b01; x_arvalid = 1'b0; x_rready = 1'b0;
        model32 = 32'd0;
        test_reset();
        test_incr_write_read();
        test_read_burst();
        test_read_stall();
        test_fixed_burst();
        test_strobe32();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_burst_ram.md
Name: axi_burst_ram

Overview:
- Single-port AXI4 slave memory model: one AXI4 write channel set (AW/W/B) and one AXI4 read channel set (AR/R) in front of a byte-strobed RAM array.
- Serves as the DRAM behind the prefetcher in system and unit benches.
- Read and write engines are independent and run concurrently.
- The prefetcher and upstream masters see it as ordinary AXI4 memory.

Parameters:
- DATA_WIDTH, 32: data bus width in bits (8..1024, power of two).
- ADDR_WIDTH, 16: byte-address width.
- STRB_WIDTH, DATA_WIDTH/8: write-strobe width; must equal DATA_WIDTH/8.
- ID_WIDTH, 8: AXI ID width.
- PIPELINE_OUTPUT, 0: 1 inserts one extra register stage on the R channel.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axi_awid  in  ID_WIDTH  write ID.
- s_axi_awaddr  in  ADDR_WIDTH  write start byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_awsize  in  3  log2 bytes per beat.
- s_axi_awburst  in  2  burst type.
- s_axi_awlock/awcache/awprot  in  1/4/3  accepted, ignored.
- s_axi_awvalid in 1; s_axi_awready out 1  AW handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  STRB_WIDTH  byte enables.
- s_axi_wlast  in  1  ignored; beat count governs.
- s_axi_wvalid in 1; s_axi_wready out 1  W handshake.
- s_axi_bid  out  ID_WIDTH  captured awid.
- s_axi_bresp  out  2  always 2'b00.
- s_axi_bvalid out 1; s_axi_bready in 1  B handshake.
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  as AW equivalents.
- s_axi_arvalid in 1; s_axi_arready out 1  AR handshake.
- s_axi_rid  out  ID_WIDTH  captured arid.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rlast  out  1  high on final beat.
- s_axi_rvalid out 1; s_axi_rready in 1  R handshake.

Behaviour:
- Memory: 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words of DATA_WIDTH. Word index = addr >> log2(STRB_WIDTH); low address bits are ignored for lane selection (always full-width lanes).
- Address step per beat:
  - burst 2'b00 (FIXED): no increment.
  - 2'b01 (INCR) and 2'b10/2'b11 (treated as INCR): add 1<<size.
  - Addresses wrap modulo 2^ADDR_WIDTH.
- Reset:
  - All outputs go low immediately: awready, wready, bvalid, arready, rvalid, rlast, bid, rid, rdata, bresp/rresp=0.
  - Both FSMs go to IDLE.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst; partially written beats remain in memory.
- Write FSM, IDLE -> BURST -> RESP:
  - IDLE: awready=1. On awvalid&&awready, capture id/addr/len/size/burst; next cycle awready=0, wready=1.
  - BURST: each wvalid&&wready writes bytes with wstrb[i]=1 and advances the address. After len+1 beats, wready=0 and bvalid=1 with bid next cycle.
  - RESP: hold bvalid until bready; then IDLE (awready=1 the following cycle).
- Read FSM, IDLE -> BURST:
  - IDLE: arready=1. AR handshake at cycle N; arready=0 from N+1.
  - PIPELINE_OUTPUT=0: beat 0 has rvalid=1, rdata, rid, rlast=(len==0) at N+1.
  - A beat advances when rvalid&&rready; the next beat is presented on the following cycle with no bubble.
  - rready=0 holds rvalid/rdata/rlast/rid stable.
  - After the last beat handshake, rvalid=0 and return to IDLE.
- PIPELINE_OUTPUT=1: one output register stage; first beat at N+2; full throughput kept via skid.
- Simultaneous events:
  - Read and write may run concurrently.
  - A same-cycle read and write of the same word returns the old data.
- No error responses.
- len=0 is a single beat.

Optional Feature:
- Macro AXI_RAM_ZERO_INIT_EN.
- Defined: every memory word is zero at time 0 (initial block), so reads of unwritten locations return 0.
- Undefined: memory is uninitialized (X in simulation).
- The macro has no effect on reset behaviour.

Decomposition:
- Package axi_pkg: burst-type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10), RESP_OKAY=2'b00, and the write/read FSM state enums.
- One natural sub-module, axi_burst_addr_gen: next address from addr, size, burst. Instantiated once per channel.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=16, ID_WIDTH=8 unless stated):
- Write addr=0x0EEF, len=3, id=5, data 0xA1,0xB2,0xC3,0xD4 -> bvalid with bid=5, bresp=0 one cycle after 4th beat. Then read 0x0EF2, len=0 -> rdata=0xD4, rlast=1, rid=5, rvalid at N+1.
- Read 0x0EEF, len=3, rready=1 -> beats 0xA1,0xB2,0xC3,0xD4 on consecutive cycles; rlast only on 4th; arready=1 again after completion.
- Read len=3 with rready=0 for 10 cycles after beat 0 -> rvalid=1, rdata=0xA1 held stable; no beat lost once rready rises.
- DATA_WIDTH=32: write 0x11223344 with wstrb=4'b0101 over 0x00000000 -> read returns 0x00220044.
- FIXED burst write len=2 at 0x0010 with 0x01,0x02,0x03 -> read 0x0010 gives 0x03; 0x0011 unchanged.
- rst asserted mid read burst -> rvalid, rlast, arready drop immediately. After release, arready=1 and a new read completes normally.
